// File: rtl/tune_sequencer.sv
// Steps through a 16-entry tune table of {note, duration}. Each step drives the
// half-period divider and tone gate for the downstream tone stage.
//
//   state  | meaning
//   IDLE   | stopped, outputs silent, waits for play
//   LOAD   | one cycle: latch table[step] into note/remaining, pulse note_strobe
//   PLAY   | sound the latched note and count tempo ticks; play=0 freezes position
//   DONE   | last step finished with loop=0; silent until restart or reset
module tune_sequencer #(
  parameter int TICK_DIV  = 6250000,
  parameter int NUM_STEPS = 16,
  parameter int DIV_W     = 17
) (
  input  logic             CLK100MHZ,
  input  logic             reset,
  input  logic             play,
  input  logic             restart,
  input  logic             loop,
  input  logic             prog_we,
  input  logic [3:0]       prog_addr,
  input  logic [7:0]       prog_data,
  output logic [DIV_W-1:0] divider,
  output logic             tone_en,
  output logic             note_strobe,
  output logic [3:0]       step,
  output logic             busy,
  output logic             done
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(TICK_DIV - 1);
  localparam logic [3:0] LAST_STEP = 4'(NUM_STEPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        step_q, step_d;
  logic [3:0]        note_q, note_d;
  logic [3:0]        rem_q, rem_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic              done_q, done_d;
  logic [7:0]        entry;

  // Tune RAM: not touched by reset; FPGA power-up content is all zero.
  logic [7:0] table_q [NUM_STEPS] = '{default: 8'h00};

  always_ff @(posedge CLK100MHZ) begin
    if (prog_we) table_q[prog_addr] <= prog_data;
  end

  function automatic logic [DIV_W-1:0] note_div(input logic [3:0] n);
    case (n)
      4'd1:    note_div = DIV_W'(113636);
      4'd2:    note_div = DIV_W'(107258);
      4'd3:    note_div = DIV_W'(101238);
      4'd4:    note_div = DIV_W'(95556);
      4'd5:    note_div = DIV_W'(90193);
      4'd6:    note_div = DIV_W'(85131);
      4'd7:    note_div = DIV_W'(80353);
      4'd8:    note_div = DIV_W'(75843);
      4'd9:    note_div = DIV_W'(71586);
      4'd10:   note_div = DIV_W'(67568);
      4'd11:   note_div = DIV_W'(63776);
      4'd12:   note_div = DIV_W'(60196);
      default: note_div = '0;
    endcase
  endfunction

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      note_q  <= '0;
      rem_q   <= '0;
      tick_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      note_q  <= note_d;
      rem_q   <= rem_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    note_d  = note_q;
    rem_d   = rem_q;
    tick_d  = tick_q;
    done_d  = done_q;
    // Combinational read of the registered RAM: a same-cycle write lands after it.
    entry   = table_q[step_q];

    if (restart) begin
      step_d = '0;
      done_d = 1'b0;
      if (play) begin
        state_d = S_LOAD;
      end else begin
        state_d = S_IDLE;
        note_d  = '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (play) state_d = S_LOAD;
        end
        S_LOAD: begin
          note_d  = entry[7:4];
          rem_d   = entry[3:0];
          tick_d  = TICK_RELOAD;
          state_d = S_PLAY;
        end
        S_PLAY: begin
          if (play) begin
            if (tick_q != '0) begin
              tick_d = tick_q - TICK_W'(1);
            end else begin
              tick_d = TICK_RELOAD;
              if (rem_q != 4'd0) begin
                rem_d = rem_q - 4'd1;
              end else if (step_q != LAST_STEP) begin
                step_d  = step_q + 4'd1;
                state_d = S_LOAD;
              end else if (loop) begin
                step_d  = '0;
                state_d = S_LOAD;
              end else begin
                state_d = S_DONE;
                done_d  = 1'b1;
                note_d  = '0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // The divider keeps showing the previous note through LOAD; the new note appears in PLAY.
  assign busy        = (state_q == S_LOAD) || (state_q == S_PLAY);
  assign note_strobe = (state_q == S_LOAD);
  assign divider     = busy ? note_div(note_q) : '0;
  assign tone_en     = busy && play && (divider != '0);
  assign step        = step_q;
  assign done        = done_q;

endmodule
